// File: rtl/stickman_pkg.sv
// Shared definitions for the StickmanRun colour path: status encoding,
// fade FSM states, palette layout and the default 8-bit-per-channel palette.
package stickman_pkg;

    localparam logic [3:0] ST_WAIT = 4'b1000;
    localparam logic [3:0] ST_PLAY = 4'b0100;
    localparam logic [3:0] ST_WIN  = 4'b0010;
    localparam logic [3:0] ST_LOSE = 4'b0001;

    typedef enum logic [1:0] {
        FADE_IDLE = 2'd0,
        FADE_OUT  = 2'd1,
        FADE_IN   = 2'd2
    } fade_state_e;

    // Offsets added to NUM_LAYERS to find the status and background entries.
    localparam int PAL_WAIT = 0;
    localparam int PAL_WIN  = 1;
    localparam int PAL_LOSE = 2;
    localparam int PAL_BG   = 3;

    localparam logic [23:0] PAL_DEF_LAYER0 = 24'h000000;
    localparam logic [23:0] PAL_DEF_LAYER1 = 24'hffff00;
    localparam logic [23:0] PAL_DEF_LAYER2 = 24'h404040;
    localparam logic [23:0] PAL_DEF_LAYER3 = 24'h101010;
    localparam logic [23:0] PAL_DEF_WAIT   = 24'h000080;
    localparam logic [23:0] PAL_DEF_WIN    = 24'h800000;
    localparam logic [23:0] PAL_DEF_LOSE   = 24'h008000;
    localparam logic [23:0] PAL_DEF_BG     = 24'h4f4f7f;

    function automatic logic [23:0] def_layer(input int idx);
        logic [23:0] c;
        case (idx)
            0:       c = PAL_DEF_LAYER0;
            1:       c = PAL_DEF_LAYER1;
            2:       c = PAL_DEF_LAYER2;
            3:       c = PAL_DEF_LAYER3;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/layered_color_mapper_fade_ctrl.sv
// Frame-paced fade controller: dims the picture out, swaps the displayed
// status at black, then brings it back in. Re-targets cleanly mid-fade.
module fade_ctrl
    import stickman_pkg::*;
#(
    parameter int FADE_STEPS = 16,
    parameter int LVL_W      = $clog2(FADE_STEPS) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [3:0]       status_i,
    input  logic             frame_start_i,
    output logic [LVL_W-1:0] level_o,
    output logic [3:0]       disp_status_o,
    output logic             busy_o
);

    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(FADE_STEPS);

    fade_state_e      state_q;
    logic [LVL_W-1:0] level_q;
    logic [3:0]       disp_q;
    logic [3:0]       tgt_q;
    logic [LVL_W-1:0] lvl_dn_d;
    logic [LVL_W-1:0] lvl_up_d;

    // Level after this cycle's frame step, clamped at both ends.
    always_comb begin
        lvl_dn_d = level_q;
        lvl_up_d = level_q;
        if (frame_start_i && (level_q != '0)) begin
            lvl_dn_d = level_q - 1'b1;
        end
        if (frame_start_i && (level_q != LVL_MAX)) begin
            lvl_up_d = level_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FADE_IDLE;
            level_q <= LVL_MAX;
            disp_q  <= ST_WAIT;
            tgt_q   <= ST_WAIT;
        end else begin
            case (state_q)
                FADE_IDLE: begin
                    level_q <= LVL_MAX;
                    if (status_i != disp_q) begin
                        tgt_q   <= status_i;
                        state_q <= FADE_OUT;
                    end
                end
                FADE_OUT: begin
                    tgt_q   <= status_i;
                    level_q <= lvl_dn_d;
                    if (status_i == disp_q) begin
                        state_q <= FADE_IN;
                    end else if (lvl_dn_d == '0) begin
                        disp_q  <= tgt_q;
                        state_q <= FADE_IN;
                    end
                end
                FADE_IN: begin
                    level_q <= lvl_up_d;
                    if (status_i != disp_q) begin
                        tgt_q   <= status_i;
                        state_q <= FADE_OUT;
                    end else if (lvl_up_d == LVL_MAX) begin
                        state_q <= FADE_IDLE;
                    end
                end
                default: begin
                    state_q <= FADE_IDLE;
                    level_q <= LVL_MAX;
                end
            endcase
        end
    end

    assign level_o       = level_q;
    assign disp_status_o = disp_q;
    assign busy_o        = (state_q != FADE_IDLE);

endmodule

// File: rtl/layered_color_mapper.sv
// Two-stage VGA colour mapper: palette/priority selection with a saturating
// background gradient, then a per-channel fade multiply driven by fade_ctrl.
module layered_color_mapper
    import stickman_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 8,
    parameter int FADE_STEPS = 16,
    parameter int GRAD_SHIFT = 3
) (
    input  logic                                 Clk,
    input  logic                                 Reset_n,
    input  logic [NUM_LAYERS-1:0]                layer_hit,
    input  logic [3:0]                           status,
    input  logic [9:0]                           DrawX,
    input  logic [9:0]                           DrawY,
    input  logic                                 pix_valid,
    input  logic                                 frame_start,
    input  logic                                 pal_we,
    input  logic [$clog2(NUM_LAYERS+4)-1:0]      pal_addr,
    input  logic [3*COLOR_W-1:0]                 pal_data,
    output logic [COLOR_W-1:0]                   VGA_R,
    output logic [COLOR_W-1:0]                   VGA_G,
    output logic [COLOR_W-1:0]                   VGA_B,
    output logic                                 pix_valid_out,
    output logic                                 fade_busy
);

    localparam int PAL_N    = NUM_LAYERS + 4;
    localparam int RGB_W    = 3 * COLOR_W;
    localparam int FADE_LOG = $clog2(FADE_STEPS);
    localparam int LVL_W    = FADE_LOG + 1;
    localparam int PROD_W   = COLOR_W + FADE_LOG + 1;
    localparam int SUB_W    = (COLOR_W > 10) ? COLOR_W : 10;

    function automatic logic [COLOR_W-1:0] scale8(input logic [7:0] v);
        logic [31:0] t;
        t = {24'd0, v};
        if (COLOR_W >= 8) begin
            t = t << ((COLOR_W >= 8) ? (COLOR_W - 8) : 0);
        end else begin
            t = t >> ((COLOR_W < 8) ? (8 - COLOR_W) : 0);
        end
        return t[COLOR_W-1:0];
    endfunction

    function automatic logic [RGB_W-1:0] pal_default(input int idx);
        logic [23:0] c;
        if (idx < NUM_LAYERS) begin
            c = def_layer(idx);
        end else begin
            case (idx - NUM_LAYERS)
                PAL_WAIT: c = PAL_DEF_WAIT;
                PAL_WIN:  c = PAL_DEF_WIN;
                PAL_LOSE: c = PAL_DEF_LOSE;
                default:  c = PAL_DEF_BG;
            endcase
        end
        return {scale8(c[23:16]), scale8(c[15:8]), scale8(c[7:0])};
    endfunction

    // Blue minus gradient offset, clamped at zero instead of wrapping.
    function automatic logic [COLOR_W-1:0] grad_sub(input logic [COLOR_W-1:0] b,
                                                    input logic [9:0]         g);
        logic signed [SUB_W:0] be;
        logic signed [SUB_W:0] ge;
        logic signed [SUB_W:0] d;
        be = (SUB_W + 1)'(b);
        ge = (SUB_W + 1)'(g);
        d  = be - ge;
        return (d <= 0) ? '0 : d[COLOR_W-1:0];
    endfunction

    function automatic logic [COLOR_W-1:0] fade_chan(input logic [COLOR_W-1:0] c,
                                                     input logic [LVL_W-1:0]   lvl);
        logic [PROD_W-1:0] p;
        p = PROD_W'(c) * PROD_W'(lvl);
        return p[FADE_LOG +: COLOR_W];
    endfunction

    logic [RGB_W-1:0]   pal_q [PAL_N];
    logic [LVL_W-1:0]   level;
    logic [3:0]         disp_status;
    logic [RGB_W-1:0]   bg;
    logic [RGB_W-1:0]   c_p1_d;
    logic [RGB_W-1:0]   c_p1_q;
    logic               vld_p1_q;
    logic [COLOR_W-1:0] r_p2_q;
    logic [COLOR_W-1:0] g_p2_q;
    logic [COLOR_W-1:0] b_p2_q;
    logic               vld_p2_q;
    logic               unused_drawy;

    assign unused_drawy = ^DrawY;

    fade_ctrl #(
        .FADE_STEPS (FADE_STEPS),
        .LVL_W      (LVL_W)
    ) u_fade (
        .clk_i         (Clk),
        .rst_ni        (Reset_n),
        .status_i      (status),
        .frame_start_i (frame_start),
        .level_o       (level),
        .disp_status_o (disp_status),
        .busy_o        (fade_busy)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < PAL_N; i++) begin
                pal_q[i] <= pal_default(i);
            end
        end else if (pal_we && (int'(pal_addr) < PAL_N)) begin
            pal_q[pal_addr] <= pal_data;
        end
    end

    // Stage 1: colour select from the displayed status and layer priority.
    always_comb begin
        c_p1_d = '0;
        bg     = pal_q[NUM_LAYERS + PAL_BG];
        if (pix_valid) begin
            case (disp_status)
                ST_WAIT: c_p1_d = pal_q[NUM_LAYERS + PAL_WAIT];
                ST_WIN:  c_p1_d = pal_q[NUM_LAYERS + PAL_WIN];
                ST_LOSE: c_p1_d = pal_q[NUM_LAYERS + PAL_LOSE];
                ST_PLAY: begin
                    c_p1_d = {bg[RGB_W-1 -: 2*COLOR_W],
                              grad_sub(bg[COLOR_W-1:0], DrawX >> GRAD_SHIFT)};
                    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
                        if (layer_hit[i]) begin
                            c_p1_d = pal_q[i];
                        end
                    end
                end
                default: c_p1_d = '0;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            c_p1_q   <= '0;
            vld_p1_q <= 1'b0;
        end else begin
            c_p1_q   <= c_p1_d;
            vld_p1_q <= pix_valid;
        end
    end

    // Stage 2: fade scaling into the output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_p2_q   <= '0;
            g_p2_q   <= '0;
            b_p2_q   <= '0;
            vld_p2_q <= 1'b0;
        end else begin
            r_p2_q   <= fade_chan(c_p1_q[RGB_W-1 -: COLOR_W], level);
            g_p2_q   <= fade_chan(c_p1_q[2*COLOR_W-1 -: COLOR_W], level);
            b_p2_q   <= fade_chan(c_p1_q[COLOR_W-1:0], level);
            vld_p2_q <= vld_p1_q;
        end
    end

    assign VGA_R         = r_p2_q;
    assign VGA_G         = g_p2_q;
    assign VGA_B         = b_p2_q;
    assign pix_valid_out = vld_p2_q;

endmodule

// File: doc/layered_color_mapper.md
Name: layered_color_mapper

Overview:
- Pipelined, parametrised successor to the combinational colour mapper for the StickmanRun VGA path.
- Takes N sprite-layer hit flags, the one-hot game status and the pixel coordinates, and produces registered VGA RGB.
- Palette is runtime-writable; the playing-screen background is a gradient with saturation.
- A status change triggers a frame-based fade-out/fade-in transition.
- Sits between the sprite/hit logic and the VGA output registers. Sync signals must be delayed by the same 2 cycles outside this block.

Parameters:
- NUM_LAYERS, 4, number of sprite layers; index 0 has the highest priority.
- COLOR_W, 8, bits per colour channel.
- FADE_STEPS, 16, fade levels; must be a power of 2, 2..256.
- GRAD_SHIFT, 3, DrawX right-shift used for the background blue gradient.

Ports:
- Clk  in  1  pixel clock
- Reset_n  in  1  asynchronous active-low reset
- layer_hit  in  NUM_LAYERS  per-layer hit flags for the current pixel
- status  in  4  {waiting, playing, win, lose}, expected one-hot
- DrawX  in  10  pixel x
- DrawY  in  10  pixel y (unused, reserved for a vertical gradient)
- pix_valid  in  1  pixel is in the active area
- frame_start  in  1  one-cycle pulse per frame
- pal_we  in  1  palette write strobe
- pal_addr  in  $clog2(NUM_LAYERS+4)  palette entry index
- pal_data  in  3*COLOR_W  {R,G,B} write data
- VGA_R, VGA_G, VGA_B  out  COLOR_W each  registered colour
- pix_valid_out  out  1  pix_valid delayed by 2 cycles
- fade_busy  out  1  high while a transition is in progress

Behaviour:
- Palette entries:
  - 0..NUM_LAYERS-1: layer colours.
  - NUM_LAYERS+0: waiting. +1: win. +2: lose. +3: playing background base.
- Palette reset values (shown for COLOR_W=8, scale for other widths):
  - Layers 0..3: 000000, ffff00, 404040, 101010. Any further layers: 000000.
  - waiting 000080, win 800000, lose 008000, background 4f4f7f.
- Palette write: takes effect for a pixel entering stage 1 on the cycle after pal_we. Writes with pal_addr out of range are ignored.
- Stage 1 (colour select) registers c1 and v1:
  - v1 = pix_valid. If pix_valid=0, c1 = 0.
  - Otherwise, decode disp_status (the displayed status, not the raw input status):
    - waiting/win/lose: the matching palette entry.
    - playing: the lowest-index set layer_hit selects its layer colour. With no hits, use the background base with B = max(0, base.B - (DrawX >> GRAD_SHIFT)). The subtraction saturates and never wraps; R and G are the base values.
    - not one-hot: black.
- Stage 2 (fade) registers the outputs:
  - VGA_x = (c1.x * level) >> log2(FADE_STEPS), with a full-width product of COLOR_W + log2(FADE_STEPS) + 1 bits.
  - level = FADE_STEPS gives an exact pass-through.
  - pix_valid_out = v1.
- Latency: exactly 2 Clk cycles from input to output, with no bubbles.
- Fade FSM (states IDLE, FADE_OUT, FADE_IN). Registers: disp_status, tgt_status, level.
  - IDLE: level = FADE_STEPS. When status != disp_status, set tgt_status = status and go to FADE_OUT.
  - FADE_OUT: on each frame_start, level--. When level reaches 0, set disp_status = tgt_status and go to FADE_IN.
  - FADE_IN: on each frame_start, level++. When level reaches FADE_STEPS, go to IDLE.
  - level only changes on frame_start; it never underflows or overflows.
- Simultaneous or interrupting events:
  - Status changes during FADE_OUT: tgt_status follows status; keep fading.
  - Status returns to disp_status during FADE_OUT: go to FADE_IN from the current level.
  - Status changes during FADE_IN: set tgt_status = status and go to FADE_OUT from the current level.
  - A status change on the same cycle as frame_start: the transition happens and level also steps per the old state.
- fade_busy = (state != IDLE).
- Reset (asynchronous, any time):
  - VGA_R/G/B = 0, pix_valid_out = 0, v1 = 0, c1 = 0.
  - state = IDLE, level = FADE_STEPS, disp_status = tgt_status = 4'b1000.
  - Palette returns to its reset values.

Decomposition:
- Shared package `stickman_pkg`:
  - Status encoding constants ST_WAIT, ST_PLAY, ST_WIN, ST_LOSE.
  - Fade state enum.
  - Palette index offsets PAL_WAIT, PAL_WIN, PAL_LOSE, PAL_BG.
  - Default palette colour constants.
- One sub-module, `fade_ctrl`: the FSM plus the level counter, outputting level, disp_status and fade_busy.
- Palette storage, selection and multiply stay in the top module.

Test Plan:
- Reset with status=0100 held → after release, disp_status=1000 and FSM enters FADE_OUT; after 16 frame_starts level=0, then 16 more bring level=16 and fade_busy=0.
- In IDLE playing with DrawX=80 and no hits → output {4f,4f,75} two cycles later. With DrawX=1016 → B saturates to 00 (127 ≥ 0x7f).
- layer_hit=4'b0110 while playing → layer 1 colour ffff00 wins over layer 2. After writing pal_addr=1 with 00ff00, the next pixel gives 00ff00.
- At fade level 8 with colour 000080 → output 000040. pix_valid=0 → 000000 with pix_valid_out=0 at +2 cycles.
- Status 1000→0010→1000 mid FADE_OUT at level 10 → FSM enters FADE_IN from 10 and reaches IDLE after 6 frame_starts.
- Non-one-hot status 0110 once displayed → black. Async reset asserted mid-FADE_IN → outputs 0 immediately with no clock.
